// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus: redirect input, instruction-memory handshake and decode-side outputs.
// if_misalign exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface pc_fetch_unit_if #(
  parameter int unsigned WordSize = 32
);

  logic                stall;
  logic                branch_taken;
  logic [WordSize-1:0] branch_addr;
  logic                imem_req_valid;
  logic [WordSize-1:0] imem_req_addr;
  logic                imem_req_ready;
  logic                imem_resp_valid;
  logic [WordSize-1:0] imem_resp_data;
  logic                if_valid;
  logic [WordSize-1:0] if_pc;
  logic [WordSize-1:0] if_inst;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                if_misalign;

  modport master (
    input  stall, branch_taken, branch_addr, imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_misalign
  );

  modport slave (
    output stall, branch_taken, branch_addr, imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_misalign
  );
`else
  modport master (
    input  stall, branch_taken, branch_addr, imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output stall, branch_taken, branch_addr, imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst
  );
`endif

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: +4 increment on request acceptance, redirect has priority.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned         WordSize    = 32,
  parameter logic [WordSize-1:0] ResetVector = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                redirect_i,
  input  logic [WordSize-1:0] target_i,
  output logic [WordSize-1:0] pc_o
);

  logic [WordSize-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + WordSize'(INST_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= ResetVector;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch FSM: one outstanding imem request, stale-response drop, registered decode outputs.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         WordSize    = 32,
  parameter logic [WordSize-1:0] ResetVector = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  pc_fetch_unit_if.master         fetch_io
);

  fetch_state_t        state_q;
  logic                drop_q;
  logic                halt_q;
  logic                req_valid_q;
  logic [WordSize-1:0] req_pc_q;
  logic                if_valid_q;
  logic [WordSize-1:0] if_pc_q;
  logic [WordSize-1:0] if_inst_q;
  logic [WordSize-1:0] pc;
  logic                accept;
  logic                mis_redirect;

  assign accept = req_valid_q & fetch_io.imem_req_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign mis_redirect = fetch_io.branch_taken & (|fetch_io.branch_addr[1:0]);
`else
  assign mis_redirect = 1'b0;
`endif

  fetch_pc_reg #(
    .WordSize   (WordSize),
    .ResetVector(ResetVector)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (accept),
    .redirect_i(fetch_io.branch_taken),
    .target_i  (fetch_io.branch_addr),
    .pc_o      (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REQ;
      drop_q      <= 1'b0;
      halt_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_pc_q    <= ResetVector;
      if_valid_q  <= 1'b0;
      if_pc_q     <= ResetVector;
      if_inst_q   <= WordSize'(NOP_INST);
    end else if (mis_redirect) begin
      // Trap: deliver a NOP tagged with the bad target and stop fetching until a fresh redirect.
      state_q     <= HOLD;
      drop_q      <= 1'b0;
      halt_q      <= 1'b1;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b1;
      if_pc_q     <= fetch_io.branch_addr;
      if_inst_q   <= WordSize'(NOP_INST);
    end else begin
      unique case (state_q)
        REQ: begin
          if (fetch_io.branch_taken) begin
            halt_q      <= 1'b0;
            req_valid_q <= 1'b0;
            if (accept) begin
              drop_q  <= 1'b1;
              state_q <= WAIT;
            end
          end else if (accept) begin
            req_pc_q    <= pc;
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end else if (!halt_q) begin
            req_valid_q <= 1'b1;
          end
        end
        WAIT: begin
          if (fetch_io.branch_taken) begin
            if (fetch_io.imem_resp_valid) begin
              drop_q      <= 1'b0;
              req_valid_q <= 1'b1;
              state_q     <= REQ;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (fetch_io.imem_resp_valid) begin
            if (drop_q) begin
              drop_q      <= 1'b0;
              req_valid_q <= 1'b1;
              state_q     <= REQ;
            end else begin
              if_valid_q <= 1'b1;
              if_pc_q    <= req_pc_q;
              if_inst_q  <= fetch_io.imem_resp_data;
              state_q    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (fetch_io.branch_taken || !fetch_io.stall) begin
            if_valid_q  <= 1'b0;
            req_valid_q <= fetch_io.branch_taken | ~halt_q;
            halt_q      <= halt_q & ~fetch_io.branch_taken;
            state_q     <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  assign fetch_io.imem_req_valid = req_valid_q;
  assign fetch_io.imem_req_addr  = pc;
  assign fetch_io.if_valid       = if_valid_q;
  assign fetch_io.if_pc          = if_pc_q;
  assign fetch_io.if_inst        = if_inst_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  // halt_q is only set by a trap, so a valid output while halted is the trap NOP.
  assign fetch_io.if_misalign    = halt_q & if_valid_q;
`endif

endmodule
